vram_scanout: RTL
=================

VRAM_SCANOUT -- requirements
Module: vram_scanout

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
- H_PIX, 64, pixels per line.
- V_PIX, 48, lines per frame.
- BASE_ADDR, 32'h00008000, byte address of pixel 0.
- FIFO_DEPTH, 4, write-FIFO entries (power of 2).
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock (rising edge).
- rst, in, 1, asynchronous active-high reset.
- video_addr, in, 32, core store byte address.
- video_data, in, 32, core store data; [23:0] is RGB.
- video_we, in, 1, core store strobe, one write per cycle high.
- scan_en, in, 1, scanout enable.
- pix_data, out, 24, RGB pixel.
- pix_valid, out, 1, pixel available.
- pix_ready, in, 1, sink accepts pixel.
- pix_sof, out, 1, qualifies pixel (0,0).
- pix_eol, out, 1, qualifies pixel x=H_PIX-1.
- frame_count, out, 16, completed frames.
- wr_overflow, out, 1, sticky dropped-write flag.
- wr_range_err, out, 1, sticky out-of-range/misaligned write flag.

Function
REQ-003 SHALL hold H_PIX*V_PIX x 24-bit pixel RAM, single-port, one access (read or write) per cycle, synchronous read with 1-cycle latency.
REQ-004 SHALL accept a write when video_we=1, video_addr[1:0]=0 and BASE_ADDR <= video_addr < BASE_ADDR+4*H_PIX*V_PIX; index = (video_addr-BASE_ADDR)>>2; data = video_data[23:0].
REQ-005 SHALL drop a write that fails REQ-004 and set wr_range_err; it never enters the FIFO.
REQ-006 SHALL push an accepted write into the FIFO, which holds index and data; writes commit to RAM in arrival order.
REQ-007 SHALL drop a write and set wr_overflow when the FIFO is full and no pop occurs that cycle; push and pop in the same cycle when full SHALL succeed.
REQ-008 SHALL keep a 2-entry pixel prefetch buffer; a read may issue only if occupancy plus in-flight reads < 2.
REQ-009 SHALL arbitrate RAM each cycle:
- FIFO full -> FIFO pop.
- Else, scanout state RUN and read permitted -> read.
- Else, FIFO non-empty -> pop.
- Else idle.
REQ-010 SHALL use a scanout FSM with states IDLE and RUN.
- IDLE -> RUN when scan_en=1, read pointer at (0,0).
- RUN -> IDLE after the read of pixel (H_PIX-1,V_PIX-1) issues and scan_en=0.
- scan_en deassert mid-frame completes the frame.
REQ-011 SHALL advance the read pointer x per issued read; at x=H_PIX-1, x wraps to 0 and y increments; at y=V_PIX-1, y wraps to 0.
REQ-012 SHALL present the buffer head on pix_data with pix_valid=1 when non-empty; a pixel transfers on pix_valid&pix_ready; pix_data/sof/eol SHALL hold stable while pix_valid&!pix_ready.
REQ-013 SHALL carry sof/eol tags with each prefetched pixel, computed from its read coordinates.
REQ-014 SHALL increment frame_count (mod 2^16) on transfer of a pixel tagged with coordinates (H_PIX-1,V_PIX-1).
REQ-015 SHALL give a read of an index with a FIFO-pending write the RAM value; no bypass; a write issued before the read is visible.
REQ-016 SHALL, with pix_ready held 1 and FIFO empty, deliver first pixel_valid 2 cycles after entering RUN, then 1 pixel per cycle.

Reset
REQ-017 SHALL, on rst=1 asynchronously: FSM IDLE; x=y=0; FIFO and prefetch empty; in-flight read cancelled; pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0, frame_count=0, wr_overflow=0, wr_range_err=0.
REQ-018 SHALL not initialise pixel RAM contents; mid-frame reset SHALL restart the next frame at (0,0).
REQ-019 SHALL clear sticky flags only by rst.

Verification
REQ-020 SHALL cover these directed scenarios:
- Write 0x00FF00 to 0x8000, 0x0000FF to 0x80FC; scan_en=1, pix_ready=1 -> pixel0=0x00FF00 with sof=1, pixel63=0x0000FF with eol=1, first valid 2 cycles after RUN.
- Write to 0x7FFC, 0x8002, 0xB000 -> wr_range_err=1, RAM and FIFO unchanged.
- scan_en=1, pix_ready=1, video_we high 8 consecutive cycles -> first 4 writes accepted; later writes each accepted only in a cycle with a pop; wr_overflow=1 iff a write was dropped; stream continues and ordering holds.
- pix_ready toggling 1,0,0,1 -> no pixel lost or duplicated; data stable while stalled.
- Full frame 3072 pixels, then scan_en=0 -> frame_count=1, FSM IDLE, pix_valid=0 after buffer drains.
- rst pulse at pixel 1000 -> all outputs reset; next frame begins with sof at (0,0).

Source files
------------

// File: rtl/vram_scanout.sv
// vram_scanout: frame-buffer RAM fed by a core write FIFO and read out in raster
// order through a 2-entry prefetch buffer with valid/ready pixel handshake.
module vram_scanout #(
  parameter int unsigned H_PIX      = 64,
  parameter int unsigned V_PIX      = 48,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] video_addr,
  input  logic [31:0] video_data,
  input  logic        video_we,
  input  logic        scan_en,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [15:0] frame_count,
  output logic        wr_overflow,
  output logic        wr_range_err
);

  localparam int unsigned NPIX = H_PIX * V_PIX;
  localparam int unsigned IW   = $clog2(NPIX);
  localparam int unsigned XW   = $clog2(H_PIX);
  localparam int unsigned YW   = $clog2(V_PIX);
  localparam int unsigned FAW  = $clog2(FIFO_DEPTH);
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(4 * NPIX);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;
  logic   run;

  // Write decode
  logic          wr_ok;
  logic [31:0]   wr_off;
  logic [IW-1:0] wr_idx;

  assign wr_ok  = (video_addr[1:0] == 2'b00) && (33'(video_addr) >= 33'(BASE_ADDR)) &&
                  (33'(video_addr) < END_ADDR);
  assign wr_off = video_addr - BASE_ADDR;
  assign wr_idx = IW'(wr_off >> 2);

  // Write FIFO
  logic [IW-1:0]  fifo_idx [FIFO_DEPTH];
  logic [23:0]    fifo_dat [FIFO_DEPTH];
  logic [FAW-1:0] f_wp_q, f_rp_q;
  logic [FAW:0]   f_cnt_q;
  logic           fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (f_cnt_q == (FAW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (f_cnt_q == '0);
  // A pop is forced whenever full, so a push into a full FIFO always has room.
  assign push       = video_we && wr_ok && (!fifo_full || pop);

  // Read pointer, in-flight read and prefetch buffer ({last, eol, sof, rgb})
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [IW-1:0] rd_idx_q;
  logic          rd_inf_q, rd_issue, rd_ok, rd_at_last;
  logic [2:0]    rd_tag_q;
  logic [23:0]   ram_q;
  logic [23:0]   mem [NPIX];
  logic [26:0]   pf0_q, pf1_q, pf0_d, pf1_d;
  logic [1:0]    pf_cnt_q, pf_cnt_d, pf_net;
  logic          xfer;

  assign pix_valid  = (pf_cnt_q != 2'd0);
  assign pix_data   = pf0_q[23:0];
  assign pix_sof    = pf0_q[24];
  assign pix_eol    = pf0_q[25];
  assign xfer       = pix_valid && pix_ready;
  assign rd_at_last = (x_q == XW'(H_PIX - 1)) && (y_q == YW'(V_PIX - 1));
  // Occupancy is taken net of this cycle's transfer so a ready sink sees one pixel per cycle.
  assign pf_net     = pf_cnt_q - 2'(xfer) + 2'(rd_inf_q);
  assign rd_ok      = (pf_net < 2'd2);

  // RAM arbitration: full FIFO first, then scanout reads, then background drain
  always_comb begin
    pop      = 1'b0;
    rd_issue = 1'b0;
    if (fifo_full) begin
      pop = 1'b1;
    end else if (run && rd_ok) begin
      rd_issue = 1'b1;
    end else if (!fifo_empty) begin
      pop = 1'b1;
    end
  end

  // Scanout FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Scanout FSM next state: a frame, once started, always runs to its last read
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (scan_en && x_q == '0 && y_q == '0) state_d = StRun;
      StRun:  if (rd_issue && rd_at_last && !scan_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Scanout FSM outputs
  always_comb begin
    run = (state_q == StRun);
  end

  // Pixel RAM: one write (FIFO pop) or one synchronous read per cycle, contents never reset
  always_ff @(posedge clk) begin
    if (pop)      mem[fifo_idx[f_rp_q]] <= fifo_dat[f_rp_q];
    if (rd_issue) ram_q <= mem[rd_idx_q];
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[f_wp_q] <= wr_idx;
      fifo_dat[f_wp_q] <= video_data[23:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_wp_q  <= '0;
      f_rp_q  <= '0;
      f_cnt_q <= '0;
    end else begin
      if (push) f_wp_q <= f_wp_q + FAW'(1);
      if (pop)  f_rp_q <= f_rp_q + FAW'(1);
      f_cnt_q <= f_cnt_q + (FAW + 1)'(push) - (FAW + 1)'(pop);
    end
  end

  // Raster read pointer and in-flight read tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      rd_idx_q <= '0;
      rd_inf_q <= 1'b0;
      rd_tag_q <= '0;
    end else begin
      rd_inf_q <= rd_issue;
      if (rd_issue) begin
        rd_tag_q <= {rd_at_last, x_q == XW'(H_PIX - 1), x_q == '0 && y_q == '0};
        if (x_q == XW'(H_PIX - 1)) begin
          x_q <= '0;
          y_q <= (y_q == YW'(V_PIX - 1)) ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
        rd_idx_q <= rd_at_last ? '0 : rd_idx_q + IW'(1);
      end
    end
  end

  // Prefetch next state: head shifts on transfer, returning read fills the first free slot
  always_comb begin
    pf0_d    = pf0_q;
    pf1_d    = pf1_q;
    pf_cnt_d = pf_cnt_q - 2'(xfer) + 2'(rd_inf_q);
    if (xfer) pf0_d = pf1_q;
    if (rd_inf_q) begin
      if (pf_cnt_q - 2'(xfer) == 2'd0) pf0_d = {rd_tag_q, ram_q};
      else                             pf1_d = {rd_tag_q, ram_q};
    end
  end

  // Prefetch buffer, frame counter and sticky write flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf0_q        <= '0;
      pf1_q        <= '0;
      pf_cnt_q     <= '0;
      frame_count  <= '0;
      wr_overflow  <= 1'b0;
      wr_range_err <= 1'b0;
    end else begin
      pf0_q    <= pf0_d;
      pf1_q    <= pf1_d;
      pf_cnt_q <= pf_cnt_d;
      if (xfer && pf0_q[26])                        frame_count  <= frame_count + 16'd1;
      if (video_we && !wr_ok)                       wr_range_err <= 1'b1;
      if (video_we && wr_ok && fifo_full && !pop)   wr_overflow  <= 1'b1;
    end
  end

endmodule
